bullet_pool: RTL and testbench

Parametrised projectile manager for the tank game. It replaces the fixed three-bullet chain with a pool of `NUM_TANKS × BULLETS_PER_TANK` slots. It handles per-tank fire arbitration, cooldown, lifetime expiry, wall reflection and round clear. It sits between the tank movers, the wall-collision checkers and `color_mapper`, and is advanced once per video frame.

---
 rtl/tank_pkg.sv | 22 ++
 rtl/bullet_slot.sv | 88 ++++++++
 rtl/bullet_pool.sv | 143 ++++++++++++++
 tb/tb_bullet_pool.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types, screen limits and the sign-extending trig shift used by the bullet pool.
package tank_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;

    typedef logic [COORD_W_DEF-1:0] coord_t;
    typedef logic signed [7:0]      trig_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COOL = 1'b1
    } tank_state_t;

    function automatic logic signed [15:0] sext_shift(input trig_t v, input int unsigned sh);
        logic signed [15:0] wide;
        wide = {{8{v[7]}}, v};
        return wide >>> sh;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One projectile slot: grant, move, reflect and expire, advanced on frame_tick.
// BULLET_BOUNCE_EN selects wall reflection; otherwise a wall hit kills the bullet.
module bullet_slot
    import tank_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int LIFETIME = 300
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               clear,
    input  logic               grant,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic [COORD_W-1:0] spawn_step_x,
    input  logic [COORD_W-1:0] spawn_step_y,
    input  logic               wall_x,
    input  logic               wall_y,
    output logic               active,
    output logic               active_next,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [COORD_W-1:0] step_x,
    output logic [COORD_W-1:0] step_y
);

    localparam int AGE_W = $clog2(LIFETIME + 1);

    logic [AGE_W-1:0]   age;
    logic [COORD_W-1:0] nsx, nsy, nx, ny;
    logic               expire;

    always_comb begin
`ifdef BULLET_BOUNCE_EN
        nsx = wall_x ? -step_x : step_x;
        nsy = wall_y ? -step_y : step_y;
`else
        nsx = step_x;
        nsy = step_y;
`endif
        nx = pos_x + nsx;
        ny = pos_y + nsy;
        // unsigned compare also catches wrap below zero
        expire = (32'(age) + 1 >= LIFETIME) || (32'(nx) >= SCREEN_W) || (32'(ny) >= SCREEN_H);
`ifndef BULLET_BOUNCE_EN
        expire = expire | wall_x | wall_y;
`endif
        active_next = active;
        if (clear)
            active_next = 1'b0;
        else if (tick) begin
            if (grant)
                active_next = 1'b1;
            else if (active)
                active_next = !expire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            pos_x  <= '0;
            pos_y  <= '0;
            step_x <= '0;
            step_y <= '0;
            age    <= '0;
        end else begin
            active <= active_next;
            if (!clear && tick) begin
                if (grant) begin
                    pos_x  <= spawn_x;
                    pos_y  <= spawn_y;
                    step_x <= spawn_step_x;
                    step_y <= spawn_step_y;
                    age    <= '0;
                end else if (active) begin
                    pos_x  <= nx;
                    pos_y  <= ny;
                    step_x <= nsx;
                    step_y <= nsy;
                    age    <= age + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// Projectile pool: fire edge capture, per-tank grant/cooldown FSMs, lowest-free slot pick, free counts.
// Wall behaviour of the slots depends on BULLET_BOUNCE_EN.
module bullet_pool
    import tank_pkg::*;
#(
    parameter int NUM_TANKS        = 2,
    parameter int BULLETS_PER_TANK = 3,
    parameter int COORD_W          = 10,
    parameter int LIFETIME         = 300,
    parameter int COOLDOWN         = 35,
    parameter int SPEED_SHIFT      = 5,
    parameter int SPAWN_SHIFT      = 2,
    parameter int NUM_SLOTS        = NUM_TANKS * BULLETS_PER_TANK
) (
    input  logic                                                   CLK,
    input  logic                                                   RESET,
    input  logic                                                   frame_tick,
    input  logic                                                   round_clear,
    input  logic [NUM_TANKS-1:0]                                   fire,
    input  logic [NUM_TANKS-1:0][COORD_W-1:0]                      tank_x,
    input  logic [NUM_TANKS-1:0][COORD_W-1:0]                      tank_y,
    input  logic [NUM_TANKS-1:0][7:0]                              sin,
    input  logic [NUM_TANKS-1:0][7:0]                              cos,
    input  logic [NUM_SLOTS-1:0]                                   wall_x,
    input  logic [NUM_SLOTS-1:0]                                   wall_y,
    output logic [NUM_SLOTS-1:0]                                   bullet_active,
    output logic [NUM_SLOTS-1:0][COORD_W-1:0]                      bullet_x,
    output logic [NUM_SLOTS-1:0][COORD_W-1:0]                      bullet_y,
    output logic [NUM_SLOTS-1:0][COORD_W-1:0]                      step_x,
    output logic [NUM_SLOTS-1:0][COORD_W-1:0]                      step_y,
    output logic [NUM_TANKS-1:0][$clog2(BULLETS_PER_TANK+1)-1:0]   free_cnt
);

    localparam int CNT_W  = $clog2(BULLETS_PER_TANK + 1);
    localparam int COOL_W = $clog2(COOLDOWN + 1);

    tank_state_t        state      [NUM_TANKS];
    tank_state_t        state_next [NUM_TANKS];
    logic [COOL_W-1:0]  cool       [NUM_TANKS];
    logic [COOL_W-1:0]  cool_next  [NUM_TANKS];
    logic [CNT_W-1:0]   free_next  [NUM_TANKS];
    logic [COORD_W-1:0] spawn_x    [NUM_TANKS];
    logic [COORD_W-1:0] spawn_y    [NUM_TANKS];
    logic [COORD_W-1:0] spawn_sx   [NUM_TANKS];
    logic [COORD_W-1:0] spawn_sy   [NUM_TANKS];
    logic [NUM_TANKS-1:0] fire_q, pending, consume, do_grant;
    logic [NUM_SLOTS-1:0] grant, active_next;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fire_q  <= '0;
            pending <= '0;
            for (int t = 0; t < NUM_TANKS; t++) begin
                state[t]    <= ST_IDLE;
                cool[t]     <= '0;
                free_cnt[t] <= CNT_W'(BULLETS_PER_TANK);
            end
        end else begin
            fire_q <= fire;
            // an edge on the tick cycle survives the consume of the old request
            pending <= round_clear ? '0 : ((pending & ~consume) | (fire & ~fire_q));
            for (int t = 0; t < NUM_TANKS; t++) begin
                state[t]    <= state_next[t];
                cool[t]     <= cool_next[t];
                free_cnt[t] <= free_next[t];
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_TANKS; t++) begin
            state_next[t] = state[t];
            cool_next[t]  = cool[t];
            if (round_clear) begin
                state_next[t] = ST_IDLE;
                cool_next[t]  = '0;
            end else if (frame_tick) begin
                case (state[t])
                    ST_IDLE: if (do_grant[t]) begin
                        state_next[t] = ST_COOL;
                        cool_next[t]  = COOL_W'(COOLDOWN - 1);
                    end
                    ST_COOL: if (cool[t] <= COOL_W'(1)) begin
                        state_next[t] = ST_IDLE;
                        cool_next[t]  = '0;
                    end else
                        cool_next[t] = cool[t] - COOL_W'(1);
                    default: state_next[t] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        logic found;
        found    = 1'b0;
        grant    = '0;
        consume  = '0;
        do_grant = '0;
        for (int t = 0; t < NUM_TANKS; t++) begin
            consume[t]  = frame_tick && !round_clear && (state[t] == ST_IDLE) && pending[t];
            do_grant[t] = consume[t] && !(&bullet_active[t*BULLETS_PER_TANK +: BULLETS_PER_TANK]);
            found       = 1'b0;
            for (int b = 0; b < BULLETS_PER_TANK; b++) begin
                if (do_grant[t] && !found && !bullet_active[t*BULLETS_PER_TANK + b]) begin
                    grant[t*BULLETS_PER_TANK + b] = 1'b1;
                    found = 1'b1;
                end
            end
            free_next[t] = '0;
            for (int b = 0; b < BULLETS_PER_TANK; b++)
                free_next[t] = free_next[t] + CNT_W'(!active_next[t*BULLETS_PER_TANK + b]);
            spawn_x[t]  = tank_x[t] + COORD_W'(sext_shift(cos[t], SPAWN_SHIFT));
            spawn_y[t]  = tank_y[t] + COORD_W'(sext_shift(sin[t], SPAWN_SHIFT));
            spawn_sx[t] = COORD_W'(sext_shift(cos[t], SPEED_SHIFT));
            spawn_sy[t] = COORD_W'(sext_shift(sin[t], SPEED_SHIFT));
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        localparam int T = s / BULLETS_PER_TANK;
        bullet_slot #(.COORD_W(COORD_W), .LIFETIME(LIFETIME)) u_slot (
            .clk          (CLK),
            .rst          (RESET),
            .tick         (frame_tick),
            .clear        (round_clear),
            .grant        (grant[s]),
            .spawn_x      (spawn_x[T]),
            .spawn_y      (spawn_y[T]),
            .spawn_step_x (spawn_sx[T]),
            .spawn_step_y (spawn_sy[T]),
            .wall_x       (wall_x[s]),
            .wall_y       (wall_y[s]),
            .active       (bullet_active[s]),
            .active_next  (active_next[s]),
            .pos_x        (bullet_x[s]),
            .pos_y        (bullet_y[s]),
            .step_x       (step_x[s]),
            .step_y       (step_y[s])
        );
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed scenarios followed by random traffic, all checked against a frame-level reference model.
module tb_bullet_pool;

    localparam int NT = 2;
    localparam int BPT = 3;
    localparam int NS = NT * BPT;

    logic CLK = 1'b0;
    logic RESET, frame_tick, round_clear;
    logic [NT-1:0] fire;
    logic [NT-1:0][9:0] tank_x, tank_y;
    logic [NT-1:0][7:0] sin_v, cos_v;
    logic [NS-1:0] wall_x, wall_y;
    logic [NS-1:0] bullet_active;
    logic [NS-1:0][9:0] bullet_x, bullet_y, step_x, step_y;
    logic [NT-1:0][1:0] free_cnt;

    int checks = 0;
    int failures = 0;

    bit m_act[NS];
    int m_x[NS], m_y[NS], m_sx[NS], m_sy[NS], m_age[NS];
    bit m_pend[NT];
    bit m_fire_prev[NT];
    int m_last[NT];
    int m_frame = 0;

    bullet_pool dut (
        .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .round_clear(round_clear),
        .fire(fire), .tank_x(tank_x), .tank_y(tank_y), .sin(sin_v), .cos(cos_v),
        .wall_x(wall_x), .wall_y(wall_y), .bullet_active(bullet_active),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .step_x(step_x), .step_y(step_y),
        .free_cnt(free_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic int wrap(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) m_act[s] = 0;
        for (int t = 0; t < NT; t++) begin
            m_pend[t] = 0; m_fire_prev[t] = 0; m_last[t] = -100000;
        end
    endtask

    // Frame-level model: a tank may fire once COOLDOWN frames have passed since its last grant.
    task automatic model_update();
        bit was_free[NS];
        bit edge_seen[NT];
        for (int t = 0; t < NT; t++) edge_seen[t] = fire[t] && !m_fire_prev[t];
        if (round_clear) begin
            for (int s = 0; s < NS; s++) m_act[s] = 0;
            for (int t = 0; t < NT; t++) begin m_pend[t] = 0; m_last[t] = -100000; end
        end else begin
            if (frame_tick) begin
                m_frame++;
                for (int s = 0; s < NS; s++) was_free[s] = !m_act[s];
                for (int s = 0; s < NS; s++) if (m_act[s]) begin
                    bit kill;
                    int nx, ny;
                    kill = 0;
`ifdef BULLET_BOUNCE_EN
                    if (wall_x[s]) m_sx[s] = -m_sx[s];
                    if (wall_y[s]) m_sy[s] = -m_sy[s];
`else
                    kill = wall_x[s] || wall_y[s];
`endif
                    nx = wrap(m_x[s] + m_sx[s]);
                    ny = wrap(m_y[s] + m_sy[s]);
                    m_x[s] = nx; m_y[s] = ny;
                    m_age[s]++;
                    if (m_age[s] >= 300 || nx >= 640 || ny >= 480) kill = 1;
                    m_act[s] = !kill;
                end
                for (int t = 0; t < NT; t++) if (m_pend[t] && (m_frame - m_last[t] >= 35)) begin
                    int c, sn, pick;
                    m_pend[t] = 0;
                    pick = -1;
                    for (int b = BPT - 1; b >= 0; b--) if (was_free[t*BPT + b]) pick = t*BPT + b;
                    if (pick >= 0) begin
                        c  = int'($signed(cos_v[t]));
                        sn = int'($signed(sin_v[t]));
                        m_act[pick] = 1;
                        m_x[pick] = wrap(int'(tank_x[t]) + (c >>> 2));
                        m_y[pick] = wrap(int'(tank_y[t]) + (sn >>> 2));
                        m_sx[pick] = c >>> 5;
                        m_sy[pick] = sn >>> 5;
                        m_age[pick] = 0;
                        m_last[t] = m_frame;
                    end
                end
            end
            for (int t = 0; t < NT; t++) if (edge_seen[t]) m_pend[t] = 1;
        end
        for (int t = 0; t < NT; t++) m_fire_prev[t] = fire[t];
    endtask

    task automatic check_all();
        for (int s = 0; s < NS; s++) begin
            chk("active", s, 32'(bullet_active[s]), 32'(m_act[s]));
            if (m_act[s]) begin
                logic [9:0] esx, esy;
                esx = 10'(m_sx[s]);
                esy = 10'(m_sy[s]);
                chk("pos_x", s, 32'(bullet_x[s]), 32'(m_x[s]));
                chk("pos_y", s, 32'(bullet_y[s]), 32'(m_y[s]));
                chk("step_x", s, 32'(step_x[s]), 32'(esx));
                chk("step_y", s, 32'(step_y[s]), 32'(esy));
            end
        end
        for (int t = 0; t < NT; t++) begin
            int n;
            n = 0;
            for (int b = 0; b < BPT; b++) if (!m_act[t*BPT + b]) n++;
            chk("free_cnt", t, 32'(free_cnt[t]), n);
        end
    endtask

    task automatic step_cycle();
        model_update();
        @(posedge CLK);
        #1;
        check_all();
        frame_tick = 0; round_clear = 0; wall_x = '0; wall_y = '0;
    endtask

    task automatic frame();
        frame_tick = 1;
        step_cycle();
        step_cycle();
        step_cycle();
    endtask

    task automatic clear_round();
        round_clear = 1;
        step_cycle();
    endtask

    initial begin
        int grants[$];
        logic [NS-1:0] prev;
        int g;
        RESET = 1; frame_tick = 0; round_clear = 0; fire = '0;
        wall_x = '0; wall_y = '0;
        tank_x[0] = 10'd100; tank_y[0] = 10'd100; cos_v[0] = 8'd64; sin_v[0] = 8'd0;
        tank_x[1] = 10'd400; tank_y[1] = 10'd300; cos_v[1] = 8'd0;  sin_v[1] = 8'd0;
        model_reset();
        repeat (3) @(posedge CLK);
        #2 RESET = 0;
        #1;
        for (int s = 0; s < NS; s++) begin
            chk("rst_active", s, 32'(bullet_active[s]), 0);
            chk("rst_x", s, 32'(bullet_x[s]), 0);
            chk("rst_y", s, 32'(bullet_y[s]), 0);
            chk("rst_sx", s, 32'(step_x[s]), 0);
            chk("rst_sy", s, 32'(step_y[s]), 0);
        end
        for (int t = 0; t < NT; t++) chk("rst_free", t, 32'(free_cnt[t]), 3);

        // first grant
        fire[0] = 1; step_cycle();
        frame();
        chk("first_active", 0, 32'(bullet_active[0]), 1);
        chk("first_x", 0, 32'(bullet_x[0]), 116);
        chk("first_y", 0, 32'(bullet_y[0]), 100);
        chk("first_sx", 0, 32'(step_x[0]), 2);
        chk("first_sy", 0, 32'(step_y[0]), 0);
        chk("first_free", 0, 32'(free_cnt[0]), 2);

        // one fire edge per frame for 100 frames: cooldown spacing and drop when full
        fire = '0; clear_round();
        for (int i = 1; i <= 100; i++) begin
            fire[0] = 1; step_cycle();
            fire[0] = 0;
            prev = bullet_active;
            frame();
            if ((bullet_active[2:0] & ~prev[2:0]) != 3'b000) grants.push_back(i);
        end
        chk("grant_count", 0, grants.size(), 3);
        g = grants.size() > 0 ? grants[0] : -1; chk("grant_tick", 0, g, 1);
        g = grants.size() > 1 ? grants[1] : -1; chk("grant_tick", 1, g, 36);
        g = grants.size() > 2 ? grants[2] : -1; chk("grant_tick", 2, g, 71);

        // right screen edge
        clear_round();
        tank_x[0] = 10'd622;
        fire[0] = 1; step_cycle(); fire[0] = 0;
        frame();
        chk("edge_spawn_x", 0, 32'(bullet_x[0]), 638);
        frame();
        chk("edge_active", 0, 32'(bullet_active[0]), 0);

        // lifetime with a stationary bullet
        clear_round();
        tank_x[0] = 10'd320; tank_y[0] = 10'd240; cos_v[0] = 8'd0;
        fire[0] = 1; step_cycle(); fire[0] = 0;
        frame();
        for (int i = 0; i < 299; i++) frame();
        chk("life_299", 0, 32'(bullet_active[0]), 1);
        frame();
        chk("life_300", 0, 32'(bullet_active[0]), 0);
        chk("life_free", 0, 32'(free_cnt[0]), 3);

        // wall hit
        clear_round();
        tank_x[0] = 10'd300; cos_v[0] = 8'd64;
        fire[0] = 1; step_cycle(); fire[0] = 0;
        frame();
        wall_x = 6'b000001;
        frame();
`ifdef BULLET_BOUNCE_EN
        chk("bounce_x", 0, 32'(bullet_x[0]), 314);
        chk("bounce_sx", 0, 32'(step_x[0]), 32'h3FE);
`else
        chk("wall_kill", 0, 32'(bullet_active[0]), 0);
`endif

        // round_clear beats a coincident tick and fire edge
        clear_round();
        fire[0] = 1; step_cycle(); fire[0] = 0;
        frame();
        round_clear = 1; frame_tick = 1; fire[0] = 1;
        step_cycle();
        chk("clr_active", 0, 32'(bullet_active), 0);
        chk("clr_free", 0, 32'(free_cnt[0]), 3);
        fire[0] = 0; step_cycle();
        fire[0] = 1; step_cycle(); fire[0] = 0;
        frame();
        chk("post_clr_grant", 0, 32'(bullet_active[0]), 1);

        // random traffic
        for (int f = 0; f < 2000; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int t = 0; t < NT; t++) begin
                    tank_x[t] = 10'($urandom_range(0, 639));
                    tank_y[t] = 10'($urandom_range(0, 479));
                    cos_v[t] = 8'($urandom);
                    sin_v[t] = 8'($urandom);
                end
            end
            fire = 2'($urandom);
            wall_x = 6'($urandom) & 6'($urandom) & 6'($urandom);
            wall_y = 6'($urandom) & 6'($urandom) & 6'($urandom);
            round_clear = ($urandom_range(0, 499) == 0);
            frame_tick = 1;
            step_cycle();
            fire = 2'($urandom);
            step_cycle();
            fire = 2'($urandom);
            step_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
